data_mem_reg_file: RTL and testbench

- Storage block for the 16-bit Harvard processor's write-back stage.
- Contains a 32-entry x 16-bit register file with two synchronous write ports and two combinational read ports.
- Contains a 256-word x 16-bit data memory with one synchronous write port and one combinational read port.
- The write-back stage drives both; it keeps register writes and memory writes mutually exclusive (mem write = not reg write), but this block does not enforce that.

---
 rtl/proc_pkg.sv | 20 ++
 rtl/data_mem_reg_file_if.sv | 35 +++
 rtl/register_file.sv | 36 +++
 rtl/data_mem_reg_file.sv | 44 ++++
 tb/tb_data_mem_reg_file.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared widths and types for the write-back storage block of the 16-bit Harvard core.
package proc_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned REG_COUNT  = 1 << REG_AW;
  localparam int unsigned MEM_AW     = 8;
  localparam int unsigned MEM_DEPTH  = 256;
  localparam int unsigned MEM_ADDR_W = 16;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_AW-1:0]     reg_addr_t;
  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

  // A data-memory address is usable only when it falls inside the physical array.
  function automatic logic mem_addr_ok(mem_addr_t addr);
    return addr < MEM_ADDR_W'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/data_mem_reg_file_if.sv
// Write-back stage bus into the register file and data memory.
interface data_mem_reg_file_if;
  import proc_pkg::*;

  logic      reg_write_en;
  reg_addr_t reg_write_dest1;
  word_t     reg_write_data1;
  reg_addr_t reg_write_dest2;
  word_t     reg_write_data2;
  reg_addr_t reg_read_addr1;
  word_t     reg_read_data1;
  reg_addr_t reg_read_addr2;
  word_t     reg_read_data2;
  logic      mem_write_en;
  mem_addr_t mem_addr;
  word_t     mem_write_data;
  word_t     mem_read_data;

  modport master (
    output reg_write_en, reg_write_dest1, reg_write_data1,
    output reg_write_dest2, reg_write_data2,
    output reg_read_addr1, reg_read_addr2,
    output mem_write_en, mem_addr, mem_write_data,
    input  reg_read_data1, reg_read_data2, mem_read_data
  );

  modport slave (
    input  reg_write_en, reg_write_dest1, reg_write_data1,
    input  reg_write_dest2, reg_write_data2,
    input  reg_read_addr1, reg_read_addr2,
    input  mem_write_en, mem_addr, mem_write_data,
    output reg_read_data1, reg_read_data2, mem_read_data
  );

endinterface

// File: rtl/register_file.sv
// 32 x 16 register file: two synchronous write ports, two combinational read ports.
module register_file
  import proc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      write_en,
  input  reg_addr_t write_dest1,
  input  word_t     write_data1,
  input  reg_addr_t write_dest2,
  input  word_t     write_data2,
  input  reg_addr_t read_addr1,
  output word_t     read_data1,
  input  reg_addr_t read_addr2,
  output word_t     read_data2
);

  word_t regs [REG_COUNT];

  // Port 2 is assigned last so it wins when both ports target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[write_dest1] <= write_data1;
      regs[write_dest2] <= write_data2;
    end
  end

  // No write-through: a same-cycle write is visible only after the edge.
  assign read_data1 = regs[read_addr1];
  assign read_data2 = regs[read_addr2];

endmodule

// File: rtl/data_mem_reg_file.sv
// Write-back storage: register file plus 256-word data memory with a 16-bit address port.
module data_mem_reg_file
  import proc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_reg_file_if.slave   bus
);

  word_t             mem [MEM_DEPTH];
  logic              mem_hit_c;
  logic [MEM_AW-1:0] mem_index_c;

  register_file u_register_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_en    (bus.reg_write_en),
    .write_dest1 (bus.reg_write_dest1),
    .write_data1 (bus.reg_write_data1),
    .write_dest2 (bus.reg_write_dest2),
    .write_data2 (bus.reg_write_data2),
    .read_addr1  (bus.reg_read_addr1),
    .read_data1  (bus.reg_read_data1),
    .read_addr2  (bus.reg_read_addr2),
    .read_data2  (bus.reg_read_data2)
  );

  assign mem_hit_c   = mem_addr_ok(bus.mem_addr);
  assign mem_index_c = bus.mem_addr[MEM_AW-1:0];

  // Out-of-range writes are dropped so high address bits never alias onto real words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.mem_write_en && mem_hit_c) begin
      mem[mem_index_c] <= bus.mem_write_data;
    end
  end

  assign bus.mem_read_data = mem_hit_c ? mem[mem_index_c] : '0;

endmodule

// File: tb/tb_data_mem_reg_file.sv
// Randomized self-checking bench for data_mem_reg_file against an array-based reference model.
module tb_data_mem_reg_file;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [15:0] ref_reg [32];
  logic [15:0] ref_mem [256];

  data_mem_reg_file_if bus ();

  data_mem_reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] ref_mem_read(input logic [15:0] a);
    if (a < 16'd256) return ref_mem[a[7:0]];
    return 16'h0000;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 32; i++) ref_reg[i] = 16'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
  endtask

  task automatic chk_reg(input logic [4:0] a1, input logic [4:0] a2);
    bus.reg_read_addr1 = a1;
    bus.reg_read_addr2 = a2;
    #1;
    check($sformatf("reg[%0d]", a1), bus.reg_read_data1, ref_reg[a1]);
    check($sformatf("reg[%0d]", a2), bus.reg_read_data2, ref_reg[a2]);
  endtask

  task automatic chk_mem(input logic [15:0] a);
    bus.mem_addr = a;
    #1;
    check($sformatf("mem[0x%04h]", a), bus.mem_read_data, ref_mem_read(a));
  endtask

  // One write cycle, started just after a falling edge; checks reads before and after the edge.
  task automatic wr(input logic ren, input logic [4:0] d1, input logic [15:0] w1,
                    input logic [4:0] d2, input logic [15:0] w2,
                    input logic men, input logic [15:0] ma, input logic [15:0] md);
    bus.reg_write_en    = ren;
    bus.reg_write_dest1 = d1;
    bus.reg_write_data1 = w1;
    bus.reg_write_dest2 = d2;
    bus.reg_write_data2 = w2;
    bus.mem_write_en    = men;
    bus.mem_addr        = ma;
    bus.mem_write_data  = md;
    bus.reg_read_addr1  = d1;
    bus.reg_read_addr2  = d2;
    #1;
    check("pre_edge_rd1", bus.reg_read_data1, ref_reg[d1]);
    check("pre_edge_rd2", bus.reg_read_data2, ref_reg[d2]);
    check("pre_edge_mem", bus.mem_read_data, ref_mem_read(ma));
    @(posedge clk);
    if (ren) begin
      ref_reg[d1] = w1;
      ref_reg[d2] = w2;
    end
    if (men && ma < 16'd256) ref_mem[ma[7:0]] = md;
    #1;
    bus.reg_write_en = 1'b0;
    bus.mem_write_en = 1'b0;
    check("post_edge_rd1", bus.reg_read_data1, ref_reg[d1]);
    check("post_edge_rd2", bus.reg_read_data2, ref_reg[d2]);
    check("post_edge_mem", bus.mem_read_data, ref_mem_read(ma));
    @(negedge clk);
  endtask

  initial begin
    logic [4:0]  d1, d2;
    logic [15:0] ma;
    bus.reg_write_en    = 1'b0;
    bus.reg_write_dest1 = '0;
    bus.reg_write_data1 = '0;
    bus.reg_write_dest2 = '0;
    bus.reg_write_data2 = '0;
    bus.reg_read_addr1  = '0;
    bus.reg_read_addr2  = '0;
    bus.mem_write_en    = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_write_data  = '0;
    rst_n = 1'b0;
    ref_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reg(5'd0, 5'd31);
    chk_mem(16'h0000);
    @(negedge clk);

    // Preload, then pulse reset mid-cycle and read back zeros before any edge.
    for (int i = 0; i < 6; i++)
      wr(1'b1, 5'($urandom), 16'($urandom), 5'($urandom), 16'($urandom | 1),
         1'b1, {8'h00, 8'($urandom)}, 16'($urandom | 1));
    wr(1'b1, 5'd3, 16'h5555, 5'd7, 16'hAAAA, 1'b1, 16'h0010, 16'h7777);
    #2;
    rst_n = 1'b0;
    ref_clear();
    chk_reg(5'd3, 5'd7);
    chk_mem(16'h0010);
    // Writes attempted while held in reset must be ignored.
    bus.reg_write_en    = 1'b1;
    bus.reg_write_dest1 = 5'd3;
    bus.reg_write_data1 = 16'h1111;
    bus.reg_write_dest2 = 5'd7;
    bus.reg_write_data2 = 16'h2222;
    bus.mem_write_en    = 1'b1;
    bus.mem_addr        = 16'h0010;
    bus.mem_write_data  = 16'h3333;
    @(posedge clk);
    #1;
    bus.reg_write_en = 1'b0;
    bus.mem_write_en = 1'b0;
    chk_reg(5'd3, 5'd7);
    chk_mem(16'h0010);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i += 2) chk_reg(5'(i), 5'(i + 1));
    @(negedge clk);

    // Directed dual write, collision, disabled write, memory in/out of range.
    wr(1'b1, 5'd3, 16'h1234, 5'd7, 16'hBEEF, 1'b0, 16'h0000, 16'h0000);
    chk_reg(5'd3, 5'd7);
    check("reg3_dual", bus.reg_read_data1, 16'h1234);
    check("reg7_dual", bus.reg_read_data2, 16'hBEEF);
    wr(1'b1, 5'd5, 16'h0001, 5'd5, 16'h0002, 1'b0, 16'h0000, 16'h0000);
    chk_reg(5'd5, 5'd0);
    check("reg5_collision", bus.reg_read_data1, 16'h0002);
    wr(1'b0, 5'd5, 16'h9999, 5'd5, 16'h8888, 1'b0, 16'h0000, 16'h0000);
    chk_reg(5'd5, 5'd5);
    check("reg5_hold", bus.reg_read_data1, 16'h0002);
    wr(1'b1, 5'd0, 16'h0F0F, 5'd31, 16'hF0F0, 1'b0, 16'h0000, 16'h0000);
    chk_reg(5'd0, 5'd31);
    check("reg0_storage", bus.reg_read_data1, 16'h0F0F);
    wr(1'b0, 5'd0, 16'h0, 5'd0, 16'h0, 1'b1, 16'h00A5, 16'hCAFE);
    chk_mem(16'h00A5);
    check("mem_a5", bus.mem_read_data, 16'hCAFE);
    chk_mem(16'h00A4);
    check("mem_a4", bus.mem_read_data, 16'h0000);
    wr(1'b0, 5'd0, 16'h0, 5'd0, 16'h0, 1'b1, 16'h01A5, 16'hFFFF);
    chk_mem(16'h01A5);
    check("mem_oor", bus.mem_read_data, 16'h0000);
    chk_mem(16'h00A5);
    check("mem_a5_kept", bus.mem_read_data, 16'hCAFE);
    chk_mem(16'hFFFF);
    @(negedge clk);

    // Alternating exclusive usage with random data.
    for (int i = 0; i < 8; i++) begin
      logic r;
      r = (i % 2 == 0);
      wr(r, 5'($urandom), 16'($urandom), 5'($urandom), 16'($urandom),
         !r, {8'h00, 8'($urandom)}, 16'($urandom));
    end

    // Free-running random traffic, including simultaneous and out-of-range writes.
    for (int i = 0; i < 150; i++) begin
      d1 = 5'($urandom);
      d2 = ($urandom_range(0, 3) == 0) ? d1 : 5'($urandom);
      ma = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      wr(1'($urandom), d1, 16'($urandom), d2, 16'($urandom),
         1'($urandom), ma, 16'($urandom));
    end

    // Full sweep against the model.
    for (int i = 0; i < 32; i += 2) chk_reg(5'(i), 5'(i + 1));
    for (int i = 0; i < 256; i++) chk_mem(16'(i));
    chk_mem(16'h0100);
    chk_mem(16'h8000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
